// File: rtl/mod_inverse_pkg.sv
`default_nettype none
// ============================================================================
// mod_inverse_pkg
// Shared arithmetic-layer constants and types for the q = 3329 primitives.
// Revision: 1.0  initial release
// ============================================================================
package mod_inverse_pkg;

  // 12-bit coefficient, shared with the add/sub/mul/Barrett blocks
  typedef logic [11:0] coeff_t;

  localparam coeff_t      KYBER_Q     = 12'd3329;
  localparam logic [12:0] MU          = 13'd5039;  // floor(2^24 / q)
  localparam coeff_t      INV_EXP     = 12'd3327;  // q - 2
  localparam int unsigned MUL_LAT     = 4;
  localparam logic [3:0]  TOP_BIT_IDX = 4'd10;     // MSB of INV_EXP seeds acc

  // FSM encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LOAD = 3'd1;
  localparam state_t ST_SQR  = 3'd2;
  localparam state_t ST_MUL  = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  // A 12-bit value is below 2q, so one conditional subtract fully reduces it
  function automatic coeff_t reduce_once(input coeff_t x);
    return (x >= KYBER_Q) ? coeff_t'(x - KYBER_Q) : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_inverse_if.sv
`default_nettype none
// ============================================================================
// mod_inverse_if
// Operand and result valid/ready channels of the modular inverter.
// Revision: 1.0  initial release
// ============================================================================
interface mod_inverse_if;
  import mod_inverse_pkg::*;

  logic   in_valid;
  logic   in_ready;
  coeff_t in_a;
  logic   out_valid;
  logic   out_ready;
  coeff_t out_inv;
  logic   out_zero;

  modport master (
    output in_valid, in_a, out_ready,
    input  in_ready, out_valid, out_inv, out_zero
  );

  modport slave (
    input  in_valid, in_a, out_ready,
    output in_ready, out_valid, out_inv, out_zero
  );
endinterface
`default_nettype wire

// File: rtl/mod_inverse_mul_pipe.sv
`default_nettype none
// ============================================================================
// mod_mul_pipe
// Free-running modular multiplier mod q: product register followed by a
// three-stage Barrett reduction, MUL_LAT cycles from operands to result.
// Revision: 1.0  initial release
// ============================================================================
module mod_mul_pipe
  import mod_inverse_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  coeff_t a,
  input  coeff_t b,
  output coeff_t prod
);

  localparam logic [13:0] Q_X1 = {2'b00, KYBER_Q};
  localparam logic [13:0] Q_X2 = {1'b0, KYBER_Q, 1'b0};

  logic [23:0] p1;
  logic [23:0] p2;
  coeff_t      t2;
  logic [13:0] r3;

  // Product, quotient estimate, remainder, then final correction. MU never
  // overestimates, so the remainder lies in [0, 3q) and at most 2q is removed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1   <= '0;
      p2   <= '0;
      t2   <= '0;
      r3   <= '0;
      prod <= '0;
    end else begin
      p1 <= 24'(a) * 24'(b);
      p2 <= p1;
      t2 <= 12'((37'(p1) * 37'(MU)) >> 24);
      r3 <= 14'(p2 - 24'(t2) * 24'(KYBER_Q));
      if (r3 >= Q_X2) begin
        prod <= 12'(r3 - Q_X2);
      end else if (r3 >= Q_X1) begin
        prod <= 12'(r3 - Q_X1);
      end else begin
        prod <= 12'(r3);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mod_inverse.sv
`default_nettype none
// ============================================================================
// mod_inverse
// Constant-time inverse mod 3329 as a^(q-2) by left-to-right
// square-and-multiply over a private pipelined multiplier.
// Revision: 1.0  initial release
// ============================================================================
module mod_inverse
  import mod_inverse_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  mod_inverse_if.slave bus
);

  state_t     state;
  state_t     next_state;
  coeff_t     acc;
  coeff_t     a_r;
  coeff_t     mul_b;
  coeff_t     mul_res;
  logic [3:0] bit_idx;
  logic [2:0] cnt;
  logic       zero_r;
  logic       op_last;
  logic       in_op;
  logic       exp_bit;

  assign in_op   = (state == ST_SQR) || (state == ST_MUL);
  assign op_last = (cnt == 3'(MUL_LAT));
  assign exp_bit = INV_EXP[bit_idx];
  assign mul_b   = (state == ST_MUL) ? a_r : acc;

  mod_mul_pipe u_mul (
    .clk   (clk),
    .reset (reset),
    .a     (acc),
    .b     (mul_b),
    .prod  (mul_res)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: one op per exponent bit, plus a multiply when the bit is set
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (bus.in_valid) next_state = ST_LOAD;
      ST_LOAD: next_state = (a_r == '0) ? ST_DONE : ST_SQR;
      ST_SQR: begin
        if (op_last) begin
          if (exp_bit)              next_state = ST_MUL;
          else if (bit_idx == 4'd0) next_state = ST_DONE;
          else                      next_state = ST_SQR;
        end
      end
      ST_MUL: begin
        if (op_last) next_state = (bit_idx == 4'd0) ? ST_DONE : ST_SQR;
      end
      ST_DONE: if (bus.out_ready) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; result and zero flag held by registers
  always_comb begin
    bus.in_ready  = (state == ST_IDLE);
    bus.out_valid = (state == ST_DONE);
    bus.out_inv   = acc;
    bus.out_zero  = zero_r;
  end

  // Datapath: operand capture, latency counter, accumulator and bit index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      a_r     <= '0;
      bit_idx <= '0;
      cnt     <= '0;
      zero_r  <= 1'b0;
    end else begin
      if (state == ST_IDLE && bus.in_valid) begin
        a_r    <= reduce_once(bus.in_a);
        acc    <= reduce_once(bus.in_a);
        zero_r <= 1'b0;
      end
      if (state == ST_LOAD) begin
        bit_idx <= TOP_BIT_IDX;
        zero_r  <= (a_r == '0);
      end
      if (in_op) begin
        if (op_last) begin
          cnt <= '0;
          acc <= mul_res;
          // advance to the next exponent bit only when starting its square
          if (next_state == ST_SQR) bit_idx <= bit_idx - 4'd1;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mod_inverse.sv
`default_nettype none
// ============================================================================
// tb_mod_inverse
// Self-checking bench for mod_inverse against a brute-force inverse model.
// Revision: 1.0  initial release
// ============================================================================
module tb_mod_inverse;
  import mod_inverse_pkg::*;

  localparam int Q       = 3329;
  localparam int LAT_NZ  = 101;
  localparam int LAT_Z   = 1;
  localparam int TIMEOUT = 300;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mod_inverse_if bus ();

  mod_inverse dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: reduce, then search for x with r*x = 1 mod q
  function automatic int ref_inv(input int a);
    int r;
    r = (a >= Q) ? a - Q : a;
    if (r == 0) return 0;
    for (int x = 1; x < Q; x++) begin
      if ((r * x) % Q == 1) return x;
    end
    return -1;
  endfunction

  // Offer one operand, wait (bounded) for out_valid; lat counts edges after accept
  task automatic run_op(input int a, output int lat, output int inv, output bit zero);
    @(negedge clk);
    bus.in_a     = 12'(a);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    inv  = int'(bus.out_inv);
    zero = bus.out_zero;
  endtask

  // Consume the result and confirm the block is idle again one edge later
  task automatic finish_op(input string name);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s handshake: out_valid=%b in_ready=%b, required 0/1",
               name, bus.out_valid, bus.in_ready);
    end
  endtask

  // Full transaction against the model: value, zero flag, latency, self-check
  task automatic check_op(input string name, input int a);
    int lat, inv, exp_inv, r, exp_lat;
    bit zero;
    exp_inv = ref_inv(a);
    r       = (a >= Q) ? a - Q : a;
    exp_lat = (r == 0) ? LAT_Z : LAT_NZ;
    run_op(a, lat, inv, zero);
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency a=%0d: got %0d cycles, required %0d", name, a, lat, exp_lat);
    end
    checks++;
    if (inv !== exp_inv) begin
      failures++;
      $display("FAIL %s out_inv a=%0d: got %0d, required %0d", name, a, inv, exp_inv);
    end
    checks++;
    if (zero !== (r == 0)) begin
      failures++;
      $display("FAIL %s out_zero a=%0d: got %b, required %b", name, a, zero, (r == 0));
    end
    if (r != 0) begin
      checks++;
      if ((inv * r) % Q != 1) begin
        failures++;
        $display("FAIL %s product a=%0d: inv*a mod q = %0d, required 1", name, a, (inv * r) % Q);
      end
    end
    finish_op(name);
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.out_inv !== 12'd0 || bus.out_zero !== 1'b0) begin
      failures++;
      $display("FAIL %s: in_ready=%b out_valid=%b out_inv=%0d out_zero=%b, required 1/0/0/0",
               name, bus.in_ready, bus.out_valid, bus.out_inv, bus.out_zero);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_state");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_known();
    check_op("known_1", 1);
    check_op("known_2", 2);
    check_op("known_17", 17);
    check_op("known_3328", 3328);
  endtask

  task automatic test_zero_and_wrap();
    check_op("zero_0", 0);
    check_op("zero_3329", 3329);
    check_op("wrap_3330", 3330);
    check_op("wrap_4095", 4095);
  endtask

  task automatic test_backpressure();
    int a, lat, inv, exp_inv;
    bit zero;
    a       = int'($urandom_range(1, Q - 1));
    exp_inv = ref_inv(a);
    run_op(a, lat, inv, zero);
    checks++;
    if (lat !== LAT_NZ || inv !== exp_inv) begin
      failures++;
      $display("FAIL bp_result a=%0d: got inv=%0d lat=%0d, required inv=%0d lat=%0d",
               a, inv, lat, exp_inv, LAT_NZ);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) begin
        bus.in_a     = 12'd7;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || int'(bus.out_inv) !== exp_inv || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b out_inv=%0d in_ready=%b, required 1/%0d/0",
                 i, bus.out_valid, bus.out_inv, bus.in_ready, exp_inv);
      end
    end
    finish_op("bp_release");
    // the pulse seen while busy must not have started a new operation
    repeat (5) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL bp_ignored: out_valid=%b in_ready=%b, required 0/1",
                 bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.in_a     = 12'd5;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_values("reset_mid_async");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_values("reset_mid_release");
    check_op("after_reset_2", 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) check_op("rand_nz", int'($urandom_range(1, Q - 1)));
    for (int i = 0; i < 15; i++) check_op("rand_full", int'($urandom_range(0, 4095)));
  endtask

  task automatic test_back_to_back();
    int a, b;
    a = int'($urandom_range(1, Q - 1));
    b = int'($urandom_range(1, Q - 1));
    check_op("b2b_first", a);
    check_op("b2b_second", b);
  endtask

  initial begin
    test_reset();
    test_known();
    test_zero_and_wrap();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod_inverse.md
# mod_inverse

Computes the multiplicative inverse of a 12-bit residue modulo q = 3329 by Fermat exponentiation, a^(q-2) mod q, using left-to-right square-and-multiply on a private pipelined modular multiplier. It undoes a modular multiply, so a multiply-by-constant path can be reversed (for example, deriving scaling constants or un-scaling twiddles) without a software round trip. It sits beside the add/sub/multiply/Barrett primitives in the arithmetic layer and uses valid/ready on both sides.

## Interface
- P, 3329: modulus; only this value is supported.
- EXP, 12'd3327: exponent q-2, binary 1100_1111_1111.
- MUL_LAT, 4: cycles from multiplier issue to registered result (1 product stage + 3 reduction stages).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- in_valid  in  1  operand offered.
- in_ready  out  1  block can accept; high only in IDLE.
- in_a  in  12  operand, any 12-bit value.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- out_inv  out  12  inverse in [0, P-1].
- out_zero  out  1  operand reduced to 0; no inverse exists and out_inv = 0.

## Operation
- Accept on in_valid & in_ready. Latch a_r = (in_a >= P) ? in_a - P : in_a. One subtraction is sufficient because in_a <= 4095 < 2P.
- If a_r == 0: skip exponentiation, go straight to DONE with out_inv = 0 and out_zero = 1.
- Otherwise: acc = a_r, which consumes the EXP MSB. Then, for each of the remaining 11 bits, MSB to LSB:
  - square: acc = acc*acc mod P;
  - if the bit is 1, multiply: acc = acc*a_r mod P.
  - This gives 11 squares and 9 multiplies, 20 operations in total.
- FSM states: IDLE → SQR → (MUL if the bit is set) → next bit SQR … → DONE → IDLE.
  - Each SQR/MUL state issues operands on its first cycle, waits MUL_LAT cycles on an internal counter, and writes acc on the last cycle.
  - A 4-bit bit index counts 10 down to 0. Leave for DONE after processing bit 0.
- DONE: out_valid = 1; out_inv = acc; out_zero is registered. Both are held stable while out_ready = 0. Return to IDLE on out_valid & out_ready.
- in_ready is 0 from the accept cycle until the return to IDLE. There is no overlap of operations: one in flight at a time.
- in_valid while busy is ignored. It is not queued.
- All multiplier operands and results are in [0, P-1]. Every acc value stays < P.

## Timing
- Reset values: in_ready = 1 (IDLE), out_valid = 0, out_inv = 0, out_zero = 0; acc, a_r, counters and the multiplier pipeline all 0.
- Each modular operation occupies exactly MUL_LAT+1 = 5 cycles.
- Latency, with the accept at edge T:
  - nonzero operand: out_valid rises at edge T+1+20·(MUL_LAT+1) = T+101;
  - zero operand: out_valid rises at T+1.
- Latency does not depend on the operand value (constant-time). Only the zero case is faster.
- Handshake on DONE:
  - out_valid & out_ready at edge D → out_valid = 0 and in_ready = 1 at D+1.
  - Earliest next accept is at D+1.
- Reset asserted mid-operation: aborts immediately to reset values. No partial result is ever presented.

## Structure
- Shared package holds:
  - KYBER_Q = 3329;
  - Barrett constant MU = 5039;
  - the 12-bit coefficient typedef, also used by the existing add/sub/mul blocks;
  - INV_EXP = 3327.
- One sub-module: mod_mul_pipe.
  - Interface: 12x12 product register followed by the 3-stage Barrett reduction, total latency MUL_LAT.
  - Uses asynchronous active-low reset. This is why it is separate from the synchronous-reset multiplier.
  - Free-running, no stall; the FSM tracks latency with its counter.
- Top level contains the FSM, acc, a_r, the bit index, and the output registers.

## Test plan
- in_a = 1 → out_inv = 1, out_zero = 0, out_valid exactly 101 cycles after accept.
- in_a = 2 → 1665; in_a = 17 → 1175; in_a = 3328 → 3328. Self-check: out_inv·in_a mod 3329 = 1.
- in_a = 0 → out_inv = 0, out_zero = 1, out_valid one cycle after accept. in_a = 3329 → same result. in_a = 3330 → out_inv = 1.
- Backpressure: out_ready held 0 for 20 cycles → out_valid and out_inv stable throughout; in_ready stays 0; a second in_valid pulse during this time is ignored.
- Reset pulse at cycle 50 of an operation → all outputs at reset values, in_ready = 1. A following in_a = 2 yields 1665 with the normal 101-cycle latency.
- Random sweep over all 1..3328 → out_inv·in_a mod 3329 = 1. Latency is constant for every operand.
